// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen
//  Purpose  : Captures W-pixel 8-bit image rows into a K-row line buffer and,
//             once K rows are held, streams every valid KxK window (K=3) to a
//             downstream MAC over a valid/ready handshake.
//  Ports    :
//    clk           - clock
//    rstn          - synchronous active-low reset
//    row_i         - packed row, column 0 in the MSBs
//    row_valid_i   - row_i valid (only sampled while idle)
//    win_ready_i   - MAC accepts the current window
//    window_o      - KxK window, element i*K+j at bits [8e+7:8e]
//                    (i=0 oldest row, j=0 leftmost column)
//    win_valid_o   - window_o valid
//    win_col_o     - left column of the current window
//    win_row_o     - top frame row of the current window
//    row_done_o    - 1-cycle pulse, ready for the next row
//    frame_done_o  - 1-cycle pulse with row_done_o after the last frame row
//  Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
  parameter int W = 24,
  parameter int H = 24,
  parameter int K = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [W*8-1:0]         row_i,
  input  logic                   row_valid_i,
  input  logic                   win_ready_i,
  output logic [K*K*8-1:0]       window_o,
  output logic                   win_valid_o,
  output logic [$clog2(W)-1:0]   win_col_o,
  output logic [$clog2(H)-1:0]   win_row_o,
  output logic                   row_done_o,
  output logic                   frame_done_o
);

  localparam int CW  = $clog2(W);
  localparam int RW  = $clog2(H);
  localparam int RCW = $clog2(H + 1);

  localparam logic [CW-1:0]  LAST_COL  = CW'(W - K);
  localparam logic [RCW-1:0] FILL_ROWS = RCW'(K);
  localparam logic [RCW-1:0] LAST_CNT  = RCW'(H);
  localparam logic [RCW-1:0] CNT_ONE   = RCW'(1);
  localparam logic [CW-1:0]  COL_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [W*8-1:0]   rows_q [K];
  logic [W*8-1:0]   rows_d [K];
  logic [RCW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]    col_q, col_d;
  logic             row_done_q, row_done_d;
  logic             frame_done_q, frame_done_d;

  logic [K*K*8-1:0] w_win;
  logic [RCW-1:0]   w_row_idx;

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    for (int i = 0; i < K; i++) rows_d[i] = rows_q[i];

    case (state_q)
      S_IDLE: begin
        if (row_valid_i) begin
          // Oldest row falls out of the top; new row enters at the bottom.
          for (int i = 0; i < K - 1; i++) rows_d[i] = rows_q[i+1];
          rows_d[K-1] = row_i;
          cnt_d       = cnt_q + CNT_ONE;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q < FILL_ROWS) begin
          row_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          col_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (win_ready_i) begin
          if (col_q == LAST_COL) begin
            // Registered pulses land in the DONE cycle, one cycle after
            // the final transfer.
            row_done_d   = 1'b1;
            frame_done_d = (cnt_q == LAST_CNT);
            state_d      = S_DONE;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      S_DONE: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          for (int i = 0; i < K; i++) rows_d[i] = '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < K; i++) rows_q[i] <= '0;
      cnt_q        <= '0;
      col_q        <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < K; i++) rows_q[i] <= rows_d[i];
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window mux: one constant-select candidate per legal left column, so
  // every line-buffer bit is reached without variable part-selects.
  always_comb begin
    w_win = '0;
    for (int c = 0; c <= W - K; c++) begin
      if (col_q == CW'(c)) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            w_win[8*(K*i+j) +: 8] = rows_q[i][W*8-8-8*(c+j) +: 8];
          end
        end
      end
    end
  end

  assign w_row_idx    = cnt_q - FILL_ROWS;

  assign win_valid_o  = (state_q == S_SCAN);
  assign window_o     = win_valid_o ? w_win : '0;
  assign win_col_o    = col_q;
  assign win_row_o    = win_valid_o ? w_row_idx[RW-1:0] : '0;
  assign row_done_o   = row_done_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Downstream consumer of the image-row source.
- Captures each W-pixel 8-bit row presented with `row_valid_i` into a 3-row line buffer.
- Once three rows are held, streams every valid 3x3 window to the convolution MAC over a valid/ready handshake.
- Pulses `row_done_o` (wired to the source's `conv_done`) when it can accept the next row, and `frame_done_o` after the last row of an image.

Parameters:
- W, 24, pixels per row (row bus width W*8).
- H, 24, rows per frame.
- K, 3, kernel size (fixed at 3; other values unsupported).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- row_i  input  W*8  packed row; column c occupies bits [W*8-1-8c -: 8] (column 0 in the MSBs)
- row_valid_i  input  1  row_i valid this cycle
- win_ready_i  input  1  MAC accepts the window this cycle
- window_o  output  72  3x3 window; element e=i*3+j occupies bits [8e+7:8e]; i=0 is the oldest row, j=0 is the leftmost column
- win_valid_o  output  1  window_o valid
- win_col_o  output  clog2(W)  left column index of the current window
- win_row_o  output  clog2(H)  top row index (frame row) of the current window
- row_done_o  output  1  1-cycle pulse; ready for the next row
- frame_done_o  output  1  1-cycle pulse coincident with row_done_o after row H-1

Behaviour:
- Reset (rstn=0 at posedge):
  - line buffer cleared to 0, state=IDLE, row count=0, col=0.
  - win_valid_o=0, row_done_o=0, frame_done_o=0, win_col_o=0, win_row_o=0, window_o=0.
- State IDLE: on row_valid_i=1, capture row_i into the buffer by shifting (row1->row0, row2->row1, row_i->row2), increment row count, go to LOAD. row_valid_i in any other state is ignored and nothing is captured.
- State LOAD (1 cycle):
  - If row count < 3 (buffer filling): pulse row_done_o, go to IDLE.
  - Otherwise: col=0, go to SCAN.
- State SCAN:
  - win_valid_o=1; window_o is taken from buffer columns col..col+2; win_col_o=col; win_row_o=row count-3.
  - window_o, win_col_o and win_row_o stay stable while win_valid_o=1 and win_ready_i=0.
  - Transfer occurs when win_valid_o and win_ready_i are both 1.
  - On transfer with col < W-3: col increments, and the next window appears in the following cycle (back-to-back throughput of one window per cycle).
  - On transfer with col = W-3: win_valid_o=0 next cycle, go to DONE.
- State DONE (1 cycle):
  - Pulse row_done_o.
  - If row count = H: also pulse frame_done_o, reset row count to 0, and clear the buffer to 0 so the next frame starts fresh.
  - Go to IDLE.
- Latency:
  - Capture to first window valid = 2 cycles (capture edge -> LOAD -> SCAN).
  - Last transfer to row_done_o = 1 cycle.
- Window count: per frame, (H-2) rows x (W-2) windows each; for the defaults, 22x22=484.
- Row count width is clog2(H+1); comparisons are done at that width, with no wrap inside a frame.
- Reset mid-SCAN: win_valid_o drops at the reset edge, no further windows are produced, and the frame restarts at row 0.
- win_ready_i is ignored while win_valid_o=0.

Test Plan:
- Reset check: hold rstn=0 for 3 cycles -> all outputs 0. Release, no stimulus for 10 cycles -> win_valid_o stays 0.
- Fill phase: send rows 0 and 1 (pixel value = row*W+col, mod 256) with win_ready_i=1 -> each produces row_done_o exactly 2 cycles after row_valid_i, and no win_valid_o.
- First windows: send row 2 with win_ready_i=1 -> win_valid_o high 2 cycles later for 22 consecutive cycles.
  - First window elements = {0,1,2,24,25,26,48,49,50} (e=0..8), win_col_o=0, win_row_o=0.
  - Last window has win_col_o=21; row_done_o pulses 1 cycle after it.
- Backpressure: in row 3, toggle win_ready_i 1,0,0,1,... -> window_o and win_col_o stay stable while ready=0, there are no skipped or duplicated columns, and exactly 22 transfers occur.
- Frame end: stream 24 rows -> 484 total windows. frame_done_o pulses once, with row_done_o, after row 23. The next row 0 produces only row_done_o and no window.
- Ignore and reset: assert row_valid_i during SCAN -> buffer unchanged (windows match the expected data). Assert rstn=0 mid-SCAN -> win_valid_o=0 next cycle; the following three rows restart with win_row_o=0.
